pwl_interp_pipe: RTL and testbench

- Parametrised, pipelined piecewise-linear activation unit for the neural-network datapath.
- Each input sample is split into a segment index and a remainder.
- The index reads two adjacent breakpoints from a run-time-programmable table, and the block computes base + ((next - base) * remaining) >>> SEG_BITS.
- Valid/ready streaming on both sides; a tag field carries the neuron/channel id alongside each sample, so one instance serves many neurons time-multiplexed.

---
 rtl/pwl_interp_pipe.sv | 152 +++++++++++++++
 tb/tb_pwl_interp_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_interp_pipe.sv
// pwl_interp_pipe: three-stage piecewise-linear interpolator with a
// run-time-programmable breakpoint table and valid/ready streaming.
//
// Each signed sample x is split into a segment index (top bits, offset so that
// the most negative segment maps to entry 0) and an unsigned remainder (low
// SEG_BITS bits). The result is base + ((next - base) * rem) >>> SEG_BITS, where
// base and next are adjacent table entries.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_data is x, in_tag is a sideband id
//   out_valid/out_ready    output handshake; out_data is the result, out_tag its id
//   cfg_we/cfg_addr/cfg_data  table write port; addresses >= DEPTH are dropped
//
// The pipeline stalls globally: when the output is held, every stage holds.
// Bubbles travel with the flow and are not collapsed.
module pwl_interp_pipe #(
  parameter int DATA_W   = 8,
  parameter int SEG_BITS = 4,
  parameter int TAG_W    = 4,
  localparam int CFG_AW  = DATA_W - SEG_BITS + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
  input  logic                     cfg_we,
  input  logic [CFG_AW-1:0]        cfg_addr,
  input  logic [DATA_W-1:0]        cfg_data
);
  localparam int ADDR_W = DATA_W - SEG_BITS;
  localparam int DEPTH  = (1 << ADDR_W) + 1;
  localparam int PW     = DATA_W + SEG_BITS + 2;
  localparam int STAGES = 3;
  localparam logic [CFG_AW-1:0] DEPTH_C = CFG_AW'(DEPTH);

  logic                       advance;
  logic [STAGES:1]            vld_pipe_d, vld_pipe_q;
  logic signed [DATA_W-1:0]   tbl_d [DEPTH];
  logic signed [DATA_W-1:0]   tbl_q [DEPTH];
  logic [CFG_AW-1:0]          rd_addr, rd_nxt;

  // S1
  logic signed [DATA_W-1:0]   s1_base_d, s1_base_q, s1_next_d, s1_next_q;
  logic [SEG_BITS-1:0]        s1_rem_d, s1_rem_q;
  logic [TAG_W-1:0]           s1_tag_d, s1_tag_q;
  // S2
  logic signed [DATA_W:0]     diff;
  logic signed [PW-1:0]       diff_x, rem_x;
  logic signed [PW-1:0]       s2_prod_d, s2_prod_q;
  logic signed [DATA_W-1:0]   s2_base_d, s2_base_q;
  logic [TAG_W-1:0]           s2_tag_d, s2_tag_q;
  // S3
  logic signed [DATA_W-1:0]   out_data_d, out_data_q;
  logic [TAG_W-1:0]           out_tag_d, out_tag_q;

  always_comb begin
    advance = !vld_pipe_q[STAGES] || out_ready;

    // Flipping the sign bit turns the signed segment index into an offset
    // index, so x = most-negative lands on entry 0. The extra top bit lets
    // addr+1 reach the last entry (DEPTH-1) without wrapping.
    rd_addr = {1'b0, ~in_data[DATA_W-1], in_data[DATA_W-2:SEG_BITS]};
    rd_nxt  = rd_addr + CFG_AW'(1);

    // Operands widened so the product of a DATA_W+1 signed difference and an
    // unsigned SEG_BITS remainder cannot overflow.
    diff   = {s1_next_q[DATA_W-1], s1_next_q} - {s1_base_q[DATA_W-1], s1_base_q};
    diff_x = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
    rem_x  = {{(PW-SEG_BITS){1'b0}}, s1_rem_q};

    vld_pipe_d = vld_pipe_q;
    s1_base_d  = s1_base_q;
    s1_next_d  = s1_next_q;
    s1_rem_d   = s1_rem_q;
    s1_tag_d   = s1_tag_q;
    s2_prod_d  = s2_prod_q;
    s2_base_d  = s2_base_q;
    s2_tag_d   = s2_tag_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;

    if (advance) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
      // Data registers only load when a real sample arrives; bubbles only
      // clear the valid bit.
      if (in_valid) begin
        s1_base_d = tbl_q[rd_addr];
        s1_next_d = tbl_q[rd_nxt];
        s1_rem_d  = in_data[SEG_BITS-1:0];
        s1_tag_d  = in_tag;
      end
      if (vld_pipe_q[1]) begin
        s2_prod_d = diff_x * rem_x;
        s2_base_d = s1_base_q;
        s2_tag_d  = s1_tag_q;
      end
      if (vld_pipe_q[2]) begin
        // Arithmetic shift floors; the sum lies between base and next, so
        // truncation to DATA_W is exact.
        out_data_d = s2_base_q + DATA_W'(s2_prod_q >>> SEG_BITS);
        out_tag_d  = s2_tag_q;
      end
    end

    // Table writes ignore the stall; S1 reads tbl_q, so a sample accepted on
    // the write edge still sees the old entry.
    tbl_d = tbl_q;
    if (cfg_we && (cfg_addr < DEPTH_C))
      tbl_d[cfg_addr] = cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_base_q  <= '0;
      s1_next_q  <= '0;
      s1_rem_q   <= '0;
      s1_tag_q   <= '0;
      s2_prod_q  <= '0;
      s2_base_q  <= '0;
      s2_tag_q   <= '0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_base_q  <= s1_base_d;
      s1_next_q  <= s1_next_d;
      s1_rem_q   <= s1_rem_d;
      s1_tag_q   <= s1_tag_d;
      s2_prod_q  <= s2_prod_d;
      s2_base_q  <= s2_base_d;
      s2_tag_q   <= s2_tag_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      tbl_q      <= tbl_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_pipe_q[STAGES];
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pwl_interp_pipe.sv
// Bench for pwl_interp_pipe: directed cases plus randomized traffic, checked
// against an arithmetic model of the interpolation and an in-order scoreboard.
module tb_pwl_interp_pipe;
  localparam int DW    = 8;
  localparam int SB    = 4;
  localparam int TW    = 4;
  localparam int AW    = DW - SB;
  localparam int DEPTH = (1 << AW) + 1;
  localparam int CAW   = AW + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  in_data = '0;
  logic [TW-1:0]  in_tag = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [DW-1:0]  out_data;
  logic [TW-1:0]  out_tag;
  logic           cfg_we = 1'b0;
  logic [CAW-1:0] cfg_addr = '0;
  logic [DW-1:0]  cfg_data = '0;

  always #5 clk = ~clk;

  pwl_interp_pipe #(.DATA_W(DW), .SEG_BITS(SB), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  typedef struct { int d; int t; } exp_t;
  exp_t q[$];
  int   tbl[DEPTH];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   held = 1'b0;
  int   hd, ht;

  task automatic chk(input string tag, input int obs, input int expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Interpolation straight from the definition: floor-divide x into a
  // segment, look up the two breakpoints, floor the scaled difference.
  function automatic int model(input logic [DW-1:0] x);
    int xs, a, r, b, n;
    xs = int'($signed(x));
    a  = (xs >>> SB) + (1 << (AW - 1));
    r  = xs & ((1 << SB) - 1);
    b  = tbl[a];
    n  = tbl[a + 1];
    return b + (((n - b) * r) >>> SB);
  endfunction

  // Monitor at the falling edge: inputs are stable, and whatever handshake is
  // seen here is what the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < DEPTH; i++) tbl[i] = 0;
      held = 1'b0;
    end else begin
      chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
      if (held) begin
        chk("hold_vld",  int'(out_valid), 1);
        chk("hold_data", int'($signed(out_data)), hd);
        chk("hold_tag",  int'(out_tag), ht);
      end
      held = out_valid && !out_ready;
      hd   = int'($signed(out_data));
      ht   = int'(out_tag);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_data", int'($signed(out_data)), e.d);
          chk("sb_tag",  int'(out_tag), e.t);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.d = model(in_data);
        e.t = int'(in_tag);
        q.push_back(e);
      end
      if (cfg_we && int'(cfg_addr) < DEPTH) tbl[int'(cfg_addr)] = int'($signed(cfg_data));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = CAW'(a);
    cfg_data = DW'(d);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] x, input logic [TW-1:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = x;
    in_tag   = t;
    while (!in_ready && n < 100) begin
      cyc();
      n++;
    end
    if (n == 100) chk("send_timeout", 0, 1);
    cyc();
    in_valid = 1'b0;
  endtask

  // Called right after the accepting edge: the result must appear two edges
  // later, not one.
  task automatic expect_out(input int d, input int t, input string tag);
    cyc();
    chk({tag, "_early"}, int'(out_valid), 0);
    cyc();
    chk({tag, "_vld"},  int'(out_valid), 1);
    chk({tag, "_data"}, int'($signed(out_data)), d);
    chk({tag, "_tag"},  int'(out_tag), t);
  endtask

  initial begin
    int sent;
    bit acc;
    #1;
    chk("rst_vld",  int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_tag",  int'(out_tag), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    wr(8, 16); wr(9, 48);
    send(8'h08, 4'd3); expect_out(32, 3, "mid");
    wr(8, 48); wr(9, 16);
    send(8'h0C, 4'd1); expect_out(24, 1, "down");
    send(8'h00, 4'd2); expect_out(48, 2, "rem0");
    wr(7, 0); wr(8, -1);
    send(8'hFF, 4'd4); expect_out(-1, 4, "floor");
    wr(16, 100); wr(15, 90);
    send(8'h7F, 4'd5); expect_out(99, 5, "top");
    wr(17, -50);
    send(8'h7F, 4'd6); expect_out(99, 6, "oob_wr");

    // Write and accept on the same edge: first sample sees old T[9].
    wr(8, 16); wr(9, 48);
    in_valid = 1'b1; in_data = 8'h08; in_tag = 4'd7;
    cfg_we = 1'b1; cfg_addr = CAW'(9); cfg_data = DW'(64);
    cyc();
    cfg_we = 1'b0; in_tag = 4'd8;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("same_edge_vld",  int'(out_valid), 1);
    chk("same_edge_data", int'($signed(out_data)), 32);
    chk("same_edge_tag",  int'(out_tag), 7);
    cyc();
    chk("after_wr_data", int'($signed(out_data)), 40);
    chk("after_wr_tag",  int'(out_tag), 8);
    cyc();

    // Back-to-back burst under a 1,0,0,1 ready pattern.
    sent = 0;
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      in_valid  = (sent < 8);
      in_data   = DW'($urandom);
      in_tag    = TW'(sent);
      #1;
      acc = in_valid && in_ready;
      cyc();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("burst_sent", sent, 8);
    repeat (4) cyc();
    chk("burst_drain", q.size(), 0);

    // Reset with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(8 + i);
      in_tag   = TW'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_rst_vld",  int'(out_valid), 1);
    chk("pre_rst_data", int'($signed(out_data)), 40);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_tag",  int'(out_tag), 0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_stale", int'(out_valid), 0);
    end
    send(8'h08, 4'd9);  expect_out(0, 9, "post_rst_t8");
    send(8'h7F, 4'd10); expect_out(0, 10, "post_rst_t15");

    // Random traffic, writes and backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 3) != 0;
      in_data   = DW'($urandom);
      in_tag    = TW'($urandom);
      out_ready = ($urandom % 4) != 0;
      cfg_we    = ($urandom % 4) == 0;
      cfg_addr  = CAW'($urandom);
      cfg_data  = DW'($urandom);
      cyc();
    end
    cfg_we = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    chk("final_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
